// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response and data-memory signals of the memory access unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_rd, mem_wr, mem_wdata
    );
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store responder with read-modify-write for sub-word stores
module mem_access_unit #(
    parameter int MEM_LAT = 1
) (
    input logic clk,
    input logic rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP, ERR} state_t;
    state_t state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]  size_q, size_d, cnt_q, cnt_d;
    logic        uns_q, uns_d, write_q, write_d;
    logic [4:0]  sh;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [31:0] ld_ext, lane_mask, lane_data, st_merge;
    logic        misaligned;
    always_comb begin
        sh         = {addr_q[1:0], 3'b000};
        rb         = 8'(bus.mem_rdata >> sh);
        rh         = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_ext     = size_q == 2'b00 ? {{24{~uns_q & rb[7]}}, rb} :
                     size_q == 2'b01 ? {{16{~uns_q & rh[15]}}, rh} : bus.mem_rdata;
        lane_mask  = size_q == 2'b00 ? 32'hFF << sh : (addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF);
        lane_data  = size_q == 2'b00 ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
        st_merge   = (bus.mem_rdata & ~lane_mask) | (lane_data & lane_mask);
        misaligned = (bus.req_size == 2'b01 & bus.req_addr[0]) | (bus.req_size[1] & |bus.req_addr[1:0]);
    end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d  = bus.req_addr;
                size_d  = bus.req_size;
                uns_d   = bus.req_unsigned;
                write_d = bus.req_write;
                wdata_d = bus.req_wdata;
                rdata_d = '0;
                state_d = misaligned ? ERR : (bus.req_write & bus.req_size[1]) ? WR_ISSUE : RD_ISSUE;
            end
            RD_ISSUE: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            // The read word is valid in the last wait cycle; stores reuse wdata_q for the merged word
            RD_WAIT: if (cnt_q == 2'(MEM_LAT - 1)) begin
                state_d = write_q ? WR_ISSUE : RESP;
                wdata_d = write_q ? st_merge : wdata_q;
                rdata_d = write_q ? rdata_q : ld_ext;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
            WR_ISSUE: state_d = RESP;
            default:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.req_ready       = state_q == IDLE & ~rst;
    assign bus.resp_valid      = state_q == RESP | state_q == ERR;
    assign bus.resp_misaligned = state_q == ERR;
    assign bus.resp_rdata      = state_q == RESP ? rdata_q : '0;
    assign bus.mem_addr        = {addr_q[31:2], 2'b00};
    assign bus.mem_rd          = state_q == RD_ISSUE;
    assign bus.mem_wr          = state_q == WR_ISSUE;
    assign bus.mem_wdata       = state_q == WR_ISSUE ? wdata_q : '0;
endmodule
